adc_128s_fc: RTL and testbench

ADC_128S_FC -- requirements
Module: adc_128s_fc

---
 rtl/adc_128s_fc.sv | 106 ++++++++++
 tb/tb_adc_128s_fc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_128s_fc.sv
`default_nettype none
// ============================================================================
//  Module   : adc_128s_fc
//  Purpose  : Behavioural model of a 12-bit, 8-channel SPI A2D converter,
//             acting as a 16-bit-frame SPI slave clocked by a system clk.
//             The command in one frame selects the channel returned in the
//             next valid frame.
//  Revision : 1.0  initial release
// ============================================================================
module adc_128s_fc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
);

    // Counter saturates one past a full frame so over-long frames are rejected
    localparam logic [4:0] c_FULL_FRAME = 5'd16;
    localparam logic [4:0] c_CNT_SAT    = 5'd17;

    logic        r_ss_ff1, r_ss_ff2, r_ss_ff3;
    logic        r_sclk_ff1, r_sclk_ff2, r_sclk_ff3;
    logic        r_mosi_ff1, r_mosi_ff2;
    logic [15:0] r_shreg;
    logic [4:0]  r_cnt;
    logic [2:0]  r_chan;

    logic        w_ss_fall;
    logic        w_ss_rise;
    logic        w_sclk_rise;
    logic [11:0] w_chan_val;

    // Bring the asynchronous SPI lines into the clk domain (third stage for edges)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_ff1   <= 1'b1;
            r_ss_ff2   <= 1'b1;
            r_ss_ff3   <= 1'b1;
            r_sclk_ff1 <= 1'b1;
            r_sclk_ff2 <= 1'b1;
            r_sclk_ff3 <= 1'b1;
            r_mosi_ff1 <= 1'b0;
            r_mosi_ff2 <= 1'b0;
        end else begin
            r_ss_ff1   <= SS_n;
            r_ss_ff2   <= r_ss_ff1;
            r_ss_ff3   <= r_ss_ff2;
            r_sclk_ff1 <= SCLK;
            r_sclk_ff2 <= r_sclk_ff1;
            r_sclk_ff3 <= r_sclk_ff2;
            r_mosi_ff1 <= MOSI;
            r_mosi_ff2 <= r_mosi_ff1;
        end
    end

    assign w_ss_fall   =  r_ss_ff3 & ~r_ss_ff2;
    assign w_ss_rise   = ~r_ss_ff3 &  r_ss_ff2;
    assign w_sclk_rise = ~r_sclk_ff3 & r_sclk_ff2;

    // Channel map; unpopulated channels read as zero
    always_comb begin
        w_chan_val = 12'h000;
        case (r_chan)
            3'd0:    w_chan_val = ld_cell_lft;
            3'd4:    w_chan_val = ld_cell_rght;
            3'd5:    w_chan_val = steerPot;
            3'd6:    w_chan_val = batt;
            default: w_chan_val = 12'h000;
        endcase
    end

    // Load the response at frame start, then shift MOSI in on each SCLK rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= 16'h0000;
            r_cnt   <= 5'd0;
        end else if (w_ss_fall) begin
            r_shreg <= {4'b0000, w_chan_val};
            r_cnt   <= 5'd0;
        end else if (w_sclk_rise && !r_ss_ff2) begin
            r_shreg <= {r_shreg[14:0], r_mosi_ff2};
            if (r_cnt != c_CNT_SAT) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Accept the command only from an exactly-16-edge frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chan <= 3'd0;
        end else if (w_ss_rise && (r_cnt == c_FULL_FRAME)) begin
            r_chan <= r_shreg[13:11];
        end
    end

    assign MISO = r_ss_ff2 ? 1'bz : r_shreg[15];

endmodule
`default_nettype wire

// File: tb/tb_adc_128s_fc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_128s_fc
//  Purpose  : Scoreboard bench for adc_128s_fc. The SPI master pushes the
//             expected response of each full frame; an independent monitor
//             assembles MISO bits and compares when the frame closes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_128s_fc;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    wire         miso_w;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] steerPot;
    logic [11:0] batt;

    pullup (miso_w);

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q[$];

    // Reference model: the channel the next frame will return
    logic [2:0]  m_ch;

    logic [15:0] mon_rx;
    int          mon_bits;

    adc_128s_fc dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (miso_w),
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .steerPot     (steerPot),
        .batt         (batt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_resp(input logic [2:0] ch);
        logic [11:0] v;
        v = 12'h000;
        if (ch == 3'd0) v = ld_cell_lft;
        else if (ch == 3'd4) v = ld_cell_rght;
        else if (ch == 3'd5) v = steerPot;
        else if (ch == 3'd6) v = batt;
        return {4'b0000, v};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_hiz(input string name);
        n_checks++;
        if (miso_w !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: MISO=%b while SS_n high, required released (pulled 1)", name, miso_w);
        end
    endtask

    // One SPI frame of nbits SCLK pulses; chg scrambles inputs after the load
    task automatic frame(input logic [15:0] cmd, input int nbits, input bit chg);
        if (nbits == 16) exp_q.push_back(model_resp(m_ch));
        SS_n = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            wait_clks(5);
            SCLK = 1'b1;
            wait_clks(5);
            if (chg && i == 2) begin
                ld_cell_lft  = 12'($urandom);
                ld_cell_rght = 12'($urandom);
                steerPot     = 12'($urandom);
                batt         = 12'($urandom);
            end
        end
        wait_clks(4);
        SS_n = 1'b1;
        MOSI = 1'b0;
        wait_clks(5);
        if (nbits == 16) m_ch = cmd[13:11];
    endtask

    // Monitor: gather MISO on each SCLK rise inside a frame
    always @(negedge SS_n) begin
        mon_bits = 0;
        mon_rx   = 16'h0000;
    end

    always @(posedge SCLK) begin
        if (!SS_n) begin
            mon_rx = {mon_rx[14:0], miso_w};
            mon_bits++;
        end
    end

    // Scoreboard compare when a full-length frame closes
    always @(posedge SS_n) begin
        if (rst_n && mon_bits == 16) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL frame_resp: got %h, no expected response queued", mon_rx);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (mon_rx !== e) begin
                    n_errors++;
                    $display("FAIL frame_resp: got %h, required %h", mon_rx, e);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_bits = 0;
        mon_rx   = 16'h0000;
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        MOSI  = 1'b0;
        ld_cell_lft = 12'h000; ld_cell_rght = 12'h000;
        steerPot = 12'h000; batt = 12'h000;
        m_ch = 3'd0;
        wait_clks(4);
        check_hiz("reset_hiz");
        rst_n = 1'b1;
        wait_clks(4);
        check_hiz("idle_hiz");

        // Directed pipeline sequence
        ld_cell_lft = 12'h156;
        frame(16'h2000, 16, 1'b0);
        check_hiz("post_frame_hiz");
        ld_cell_rght = 12'h156;
        frame(16'h2800, 16, 1'b0);
        steerPot = 12'h100; batt = 12'h900;
        frame(16'h3000, 16, 1'b0);
        frame(16'h0000, 16, 1'b0);
        frame(16'h0800, 16, 1'b0);
        frame(16'h0000, 16, 1'b0);
        frame(16'h0800, 16, 1'b0);

        // Short frame commanding ch6 is discarded
        frame(16'h3000, 10, 1'b0);
        frame(16'h3000, 16, 1'b0);

        // Stray SCLK with SS_n high must not disturb anything
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; wait_clks(5);
            SCLK = 1'b1; wait_clks(5);
        end
        MOSI = 1'b0;
        check_hiz("stray_sclk_hiz");
        frame(16'h0000, 16, 1'b0);

        // ch6 commanded, then reset mid-frame
        frame(16'h3000, 16, 1'b0);
        SS_n = 1'b0;
        wait_clks(6);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0; wait_clks(5);
            SCLK = 1'b1; wait_clks(5);
        end
        rst_n = 1'b0;
        wait_clks(2);
        SS_n = 1'b1;
        wait_clks(2);
        check_hiz("midframe_reset_hiz");
        rst_n = 1'b1;
        m_ch = 3'd0;
        wait_clks(5);
        ld_cell_lft = 12'hABC;
        frame(16'h0000, 16, 1'b1);

        // Randomized frames, including bad lengths and mid-frame input changes
        for (int k = 0; k < 40; k++) begin
            int nb;
            ld_cell_lft  = 12'($urandom);
            ld_cell_rght = 12'($urandom);
            steerPot     = 12'($urandom);
            batt         = 12'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
            frame(16'($urandom), nb, 1'($urandom));
        end

        wait_clks(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d responses never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
